// File: rtl/nibble_adder_pkg.sv
// Shared types for the nibble-serial adder: nibble width, FSM state and nibble type.
package nibble_adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  typedef logic [NIB_W-1:0] nibble_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// NIBBLE_SERIAL_SUB_EN adds the 'sub' request bit sampled with the operands.
interface nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Co;

`ifdef NIBBLE_SERIAL_SUB_EN
  modport master (
    output in_valid, A, B, Ci, sub, out_ready,
    input  in_ready, out_valid, S, Co
  );

  modport slave (
    input  in_valid, A, B, Ci, sub, out_ready,
    output in_ready, out_valid, S, Co
  );
`else
  modport master (
    output in_valid, A, B, Ci, out_ready,
    input  in_ready, out_valid, S, Co
  );

  modport slave (
    input  in_valid, A, B, Ci, out_ready,
    output in_ready, out_valid, S, Co
  );
`endif

endinterface

// File: rtl/add4_slice.sv
// Combinational 4-bit adder slice with carry in/out; the only arithmetic in the serial adder.
module add4_slice
  import nibble_adder_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    ci,
  output nibble_t s,
  output logic    co
);

  assign {co, s} = a + b + ci;

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that adds WIDTH-bit operands one nibble per clock through a single add4_slice.
// Optional NIBBLE_SERIAL_SUB_EN: bus.sub=1 computes A-B (Co=1 means no borrow).
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus,
  output logic                 busy
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  state_t               state;
  nibble_t [NIB-1:0]    a_q;
  nibble_t [NIB-1:0]    b_q;
  nibble_t [NIB-1:0]    s_q;
  logic [IDX_W-1:0]     idx;
  logic                 carry;
  logic                 co_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  nibble_t              sum4;
  logic                 cout;

  add4_slice u_slice (
    .a  (a_q[idx]),
    .b  (b_q[idx]),
    .ci (carry),
    .s  (sum4),
    .co (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      co_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            a_q <= bus.A;
`ifdef NIBBLE_SERIAL_SUB_EN
            // Subtract as A + ~B + 1; Ci is not used in that mode.
            b_q   <= bus.sub ? ~bus.B : bus.B;
            carry <= bus.sub ? 1'b1 : bus.Ci;
`else
            b_q   <= bus.B;
            carry <= bus.Ci;
`endif
            idx        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
            state      <= ADD;
          end
        end

        ADD: begin
          s_q[idx] <= sum4;
          carry    <= cout;
          if (idx == LAST) begin
            co_q        <= cout;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          // in_ready is raised together with the handshake so the next accept can follow one cycle later.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.Co        = co_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder (WIDTH=16); subtract vectors run when NIBBLE_SERIAL_SUB_EN is defined.
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_vec;
  int   n_err;
  int   cyc;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for in_ready with operands presented, then step past the accept edge.
  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic ci);
    bus.A        = a;
    bus.B        = b;
    bus.Ci       = ci;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !bus.in_ready; i++) step();
    check("accept_ready", 32'(bus.in_ready), 1);
    step();
  endtask

  task automatic wait_out(input string tag, output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 40) begin
      step();
      cycles++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_latency"}, 32'(cycles), 4);
  endtask

  task automatic do_tx(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic [15:0] exp_s, input logic exp_co);
    int c;
    accept(a, b, ci);
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_in_ready_add"}, 32'(bus.in_ready), 0);
    wait_out(tag, c);
    check({tag, "_S"}, 32'(bus.S), 32'(exp_s));
    check({tag, "_Co"}, 32'(bus.Co), 32'(exp_co));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_clr"}, 32'(bus.out_valid), 0);
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Ci        = 1'b0;
    bus.out_ready = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    bus.sub       = 1'b0;
`endif

    repeat (2) step();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_S", 32'(bus.S), 0);
    check("rst_Co", 32'(bus.Co), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(bus.in_ready), 1);

    do_tx("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_tx("mix", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);

    // Result held under backpressure while new operands wait at the input.
    accept(16'h0F0F, 16'h0101, 1'b0);
    bus.in_valid = 1'b0;
    wait_out("bp", cyc);
    bus.A        = 16'hAAAA;
    bus.B        = 16'h5555;
    bus.Ci       = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_S", 32'(bus.S), 'h1010);
      check("bp_Co", 32'(bus.Co), 0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("bp_release_valid", 32'(bus.out_valid), 0);
    check("bp_release_ready", 32'(bus.in_ready), 1);
    check("bp_release_busy", 32'(busy), 0);
    step();
    check("bp_next_busy", 32'(busy), 1);
    check("bp_next_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    wait_out("bp_next", cyc);
    check("bp_next_S", 32'(bus.S), 'h0000);
    check("bp_next_Co", 32'(bus.Co), 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Reset after two nibbles have been summed.
    accept(16'h1111, 16'h2222, 1'b0);
    bus.in_valid = 1'b0;
    repeat (2) step();
    check("midrst_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_S", 32'(bus.S), 0);
    check("midrst_Co", 32'(bus.Co), 0);
    check("midrst_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;
    step();
    check("midrst_in_ready", 32'(bus.in_ready), 1);
    do_tx("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

`ifdef NIBBLE_SERIAL_SUB_EN
    bus.sub = 1'b1;
    do_tx("sub_borrow", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    do_tx("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
    bus.sub = 1'b0;
`endif

    // Back-to-back with out_ready tied high.
    bus.out_ready = 1'b1;
    accept(16'h8000, 16'h8000, 1'b0);
    bus.A  = 16'h0FFF;
    bus.B  = 16'h0001;
    bus.Ci = 1'b1;
    wait_out("b2b_first", cyc);
    check("b2b_first_S", 32'(bus.S), 'h0000);
    check("b2b_first_Co", 32'(bus.Co), 1);
    step();
    check("b2b_hs_valid", 32'(bus.out_valid), 0);
    check("b2b_hs_ready", 32'(bus.in_ready), 1);
    step();
    check("b2b_second_busy", 32'(busy), 1);
    check("b2b_second_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    wait_out("b2b_second", cyc);
    check("b2b_second_S", 32'(bus.S), 'h1001);
    check("b2b_second_Co", 32'(bus.Co), 0);
    step();
    bus.out_ready = 1'b0;
    check("b2b_done_valid", 32'(bus.out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
